mem_arbiter: RTL

Registered memory arbiter between the instruction cache, the data cache and the single-ported RAM. Accepts one word request at a time from either cache, drives the RAM until it reports ACCESS, then returns read data with a one-cycle wait-release pulse. Data-cache priority, with an anti-starvation rule for the instruction cache and bounded retry on RAM errors.

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Registered arbiter sharing one single-ported RAM between the instruction and data caches.
// One word transaction at a time: data-cache priority, icache anti-starvation, bounded retry on RAM errors.
module mem_arbiter #(
  parameter int unsigned MAX_RETRY = 3,
  parameter logic [31:0] ERR_WORD  = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

  state_t        state, state_next;
  logic          grant_d;
  logic          op_write;
  logic          last_d;
  logic [RW-1:0] retry;
  logic          d_req;
  logic          pick_d;
  logic          give_up;

  assign d_req   = dREN | dWEN;
  // The icache gets the grant right after a completed dcache transaction if it is waiting.
  assign pick_d  = d_req & ~(last_d & iREN);
  assign give_up = (ramstate == RAM_ERROR) && (retry == RETRY_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    unique case (state)
      IDLE: begin
        if (iREN | d_req) state_next = SERVE;
      end
      SERVE: begin
        ramREN = ~op_write;
        ramWEN = op_write;
        if (ramstate == RAM_ACCESS || give_up) state_next = RESP;
      end
      RESP: begin
        iwait      = grant_d;
        dwait      = ~grant_d;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      grant_d  <= 1'b0;
      op_write <= 1'b0;
      last_d   <= 1'b0;
      retry    <= '0;
      ramaddr  <= '0;
      ramstore <= '0;
      iload    <= '0;
      dload    <= '0;
      memerr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iREN | d_req) begin
            grant_d  <= pick_d;
            op_write <= pick_d & dWEN;
            ramaddr  <= pick_d ? daddr : iaddr;
            if (pick_d) ramstore <= dstore;
          end
        end
        SERVE: begin
          if (ramstate == RAM_ACCESS) begin
            if (!op_write) begin
              if (grant_d) dload <= ramload;
              else         iload <= ramload;
            end
          end else if (ramstate == RAM_ERROR) begin
            retry <= retry + RW'(1);
            // Aborted reads hand back a recognisable poison word; aborted writes touch nothing.
            if (give_up) begin
              memerr <= 1'b1;
              if (!op_write) begin
                if (grant_d) dload <= ERR_WORD;
                else         iload <= ERR_WORD;
              end
            end
          end
        end
        RESP: begin
          last_d <= grant_d;
          retry  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
